// File: rtl/rgb_fade_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// rgb_fade_ctrl
//
// Sequences the three PWM inputs (RGB0PWM/RGB1PWM/RGB2PWM) and RGBLEDEN of the
// iCE40 SB_RGBA_DRV hard LED driver. Each colour holds a duty value. A
// free-running counter turns that duty into glitch-free PWM. Fade commands
// arrive over a valid/ready handshake, and each colour then ramps linearly
// toward its target at a programmable rate.
//
// Ports
//   clk        system clock (SB_HFOSC output)
//   rst_n      asynchronous active-low reset
//   led_en_in  LED enable request; registered onto led_en
//   cmd_valid  fade command valid; hold it until cmd_ready is seen high
//   cmd_ready  controller is idle and accepts a command this cycle
//   cmd_r/g/b  target duties for the fade
//   cmd_div    clocks per fade step minus one
//   abort      stop the fade in progress; duties freeze where they are
//   pwm_r/g/b  registered PWM outputs to the driver
//   led_en     registered enable output to RGBLEDEN
//   busy       fade in progress
//   done       single-cycle pulse when a fade reaches all of its targets
// -----------------------------------------------------------------------------
module rgb_fade_ctrl #(
  parameter int PWM_BITS = 8,
  parameter int DIV_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                led_en_in,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [PWM_BITS-1:0] cmd_r,
  input  logic [PWM_BITS-1:0] cmd_g,
  input  logic [PWM_BITS-1:0] cmd_b,
  input  logic [DIV_BITS-1:0] cmd_div,
  input  logic                abort,
  output logic                pwm_r,
  output logic                pwm_g,
  output logic                pwm_b,
  output logic                led_en,
  output logic                busy,
  output logic                done
);

  localparam int                NCH     = 3;
  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

  typedef enum logic {
    IDLE = 1'b0,
    FADE = 1'b1
  } state_t;

  state_t state_reg, state_next;

  logic [PWM_BITS-1:0] pwm_cnt_reg;
  logic [DIV_BITS-1:0] div_reg;
  logic [DIV_BITS-1:0] presc_reg;
  logic                led_en_reg;

  // Per-channel storage. Index 0 = red, 1 = green, 2 = blue.
  logic [PWM_BITS-1:0] cmd_duty     [NCH];
  logic [PWM_BITS-1:0] tgt_reg      [NCH];
  logic [PWM_BITS-1:0] duty_reg     [NCH];
  logic [PWM_BITS-1:0] duty_act_reg [NCH];
  logic [NCH-1:0]      pwm_reg;
  logic [NCH-1:0]      at_tgt;

  logic accept;      // command handshake completes this cycle
  logic tick;        // prescaler wraps this cycle while fading
  logic step;        // duties move one LSB this cycle
  logic all_at_tgt;
  logic period_end;  // last clock of the PWM period

  assign cmd_duty[0] = cmd_r;
  assign cmd_duty[1] = cmd_g;
  assign cmd_duty[2] = cmd_b;

  assign period_end = (pwm_cnt_reg == CNT_MAX);
  assign all_at_tgt = &at_tgt;

  // An aborted cycle must not step, so the duties freeze at the values that
  // were visible when abort was raised.
  assign step = tick && !abort;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic and handshake/status outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cmd_ready  = 1'b0;
    accept     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    tick       = 1'b0;
    case (state_reg)
      IDLE: begin
        // ready stays low while reset is asserted, even though the state
        // register already reads IDLE.
        cmd_ready = rst_n;
        accept    = cmd_valid && rst_n;
        if (accept) begin
          state_next = FADE;
        end
      end
      FADE: begin
        busy = 1'b1;
        tick = (presc_reg == div_reg);
        // Abort wins over completion, so no done pulse is produced when both
        // happen in the same cycle.
        if (abort) begin
          state_next = IDLE;
        end else if (all_at_tgt) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // PWM period counter, fade-rate prescaler, and LED enable
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_reg <= '0;
      div_reg     <= '0;
      presc_reg   <= '0;
      led_en_reg  <= 1'b0;
    end else begin
      pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
      led_en_reg  <= led_en_in;
      if (accept) begin
        div_reg   <= cmd_div;
        presc_reg <= '0;
      end else if (state_reg == FADE) begin
        if (tick) begin
          presc_reg <= '0;
        end else begin
          presc_reg <= presc_reg + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel target, ramp, shadow duty, and PWM compare
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tgt_reg[gi]      <= '0;
        duty_reg[gi]     <= '0;
        duty_act_reg[gi] <= '0;
        pwm_reg[gi]      <= 1'b0;
      end else begin
        if (accept) begin
          tgt_reg[gi] <= cmd_duty[gi];
        end
        // The comparisons guard the +/-1, so the duty can neither overshoot
        // its target nor wrap.
        if (step) begin
          if (duty_reg[gi] < tgt_reg[gi]) begin
            duty_reg[gi] <= duty_reg[gi] + 1'b1;
          end else if (duty_reg[gi] > tgt_reg[gi]) begin
            duty_reg[gi] <= duty_reg[gi] - 1'b1;
          end
        end
        // The comparator only sees a new duty at the period boundary. This
        // rules out truncated or doubled pulses mid-period.
        if (period_end) begin
          duty_act_reg[gi] <= duty_reg[gi];
        end
        pwm_reg[gi] <= (duty_act_reg[gi] > pwm_cnt_reg);
      end
    end

    assign at_tgt[gi] = (duty_reg[gi] == tgt_reg[gi]);
  end

  assign pwm_r  = pwm_reg[0];
  assign pwm_g  = pwm_reg[1];
  assign pwm_b  = pwm_reg[2];
  assign led_en = led_en_reg;

endmodule

// File: tb/tb_rgb_fade_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_rgb_fade_ctrl
//
// Directed bench for rgb_fade_ctrl. Inputs are driven 1 ns after each rising
// edge, and outputs are sampled at that same point. Expected values are
// worked out by hand from the fade/PWM timing rules.
// -----------------------------------------------------------------------------
module tb_rgb_fade_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       led_en_in;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_r, cmd_g, cmd_b;
  logic [15:0] cmd_div;
  logic       abort;
  logic       pwm_r, pwm_g, pwm_b;
  logic       led_en;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rgb_fade_ctrl #(.PWM_BITS(8), .DIV_BITS(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .led_en_in (led_en_in),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_r     (cmd_r),
    .cmd_g     (cmd_g),
    .cmd_b     (cmd_b),
    .cmd_div   (cmd_div),
    .abort     (abort),
    .pwm_r     (pwm_r),
    .pwm_g     (pwm_g),
    .pwm_b     (pwm_b),
    .led_en    (led_en),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (cmd_ready === 1'b1) break;
      step_clk();
    end
    chk("wait_idle", cmd_ready, 1);
  endtask

  task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input logic [15:0] d);
    cmd_r = r; cmd_g = g; cmd_b = b; cmd_div = d; cmd_valid = 1'b1;
    step_clk();
    cmd_valid = 1'b0;
  endtask

  task automatic count_pwm(output int nr, output int ng, output int nb);
    nr = 0; ng = 0; nb = 0;
    for (int i = 0; i < 256; i++) begin
      nr += int'(pwm_r); ng += int'(pwm_g); nb += int'(pwm_b);
      step_clk();
    end
  endtask

  // The shadow duty for red may only change on the edge where the counter
  // sits at its maximum.
  logic [7:0] prev_act;
  logic [7:0] prev_cnt;
  logic       prev_ok = 1'b0;
  always @(negedge clk) begin
    if (rst_n && prev_ok && (dut.duty_act_reg[0] !== prev_act))
      chk("act_at_wrap", prev_cnt, 8'hFF);
    prev_act = dut.duty_act_reg[0];
    prev_cnt = dut.pwm_cnt_reg;
    prev_ok  = rst_n;
  end

  initial begin
    int first_done, ndone, acc_k, nr, ng, nb;
    logic [7:0] d;

    rst_n = 1'b0; led_en_in = 1'b0; cmd_valid = 1'b0; abort = 1'b0;
    cmd_r = '0; cmd_g = '0; cmd_b = '0; cmd_div = '0;

    // 1. Reset
    repeat (5) step_clk();
    chk("rst_pwm", {pwm_r, pwm_g, pwm_b}, 0);
    chk("rst_ready_low", cmd_ready, 0);
    chk("rst_busy_done", {busy, done, led_en}, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", cmd_ready, 1);
    chk("rel_outs", {pwm_r, pwm_g, pwm_b, led_en, busy, done}, 0);
    chk("rel_cnt", dut.pwm_cnt_reg, 0);
    led_en_in = 1'b1;
    #1;
    chk("led_en_reg_lat", led_en, 0);
    step_clk();
    chk("led_en", led_en, 1);

    // 2. Full fade: r=255, g=0, b=128, div=0
    cmd_r = 8'd255; cmd_g = 8'd0; cmd_b = 8'd128; cmd_div = 16'd0; cmd_valid = 1'b1;
    #1;
    chk("full_ready_T", cmd_ready, 1);
    step_clk();
    cmd_valid = 1'b0;
    first_done = 0; ndone = 0;
    for (int k = 1; k <= 256; k++) begin
      if (done) begin ndone++; if (first_done == 0) first_done = k; end
      if (k == 1) begin
        chk("full_busy_T1", busy, 1);
        chk("full_ready_T1", cmd_ready, 0);
      end
      step_clk();
    end
    chk("full_done_cycle", first_done, 256);
    chk("full_done_count", ndone, 1);
    chk("full_ready_T257", cmd_ready, 1);
    chk("full_busy_T257", busy, 0);
    chk("full_duty_r", dut.duty_reg[0], 255);
    chk("full_duty_b", dut.duty_reg[2], 128);
    repeat (300) step_clk();
    count_pwm(nr, ng, nb);
    chk("pwm_r_255", nr, 255);
    chk("pwm_g_0", ng, 0);
    chk("pwm_b_128", nb, 128);

    // 3. Rate and down-ramp: r 10 -> 6, div=3
    send(8'd10, 8'd0, 8'd128, 16'd0);
    wait_idle(400);
    chk("ramp_start_r", dut.duty_reg[0], 10);
    send(8'd6, 8'd0, 8'd128, 16'd3);
    first_done = 0;
    for (int k = 1; k <= 17; k++) begin
      chk($sformatf("ramp_r_k%0d", k), dut.duty_reg[0], 10 - (k - 1) / 4);
      if (done && first_done == 0) first_done = k;
      step_clk();
    end
    chk("ramp_done_cycle", first_done, 17);
    chk("ramp_ready_after", cmd_ready, 1);

    // 4. Handshake: held command accepted only when ready returns
    send(8'd60, 8'd0, 8'd128, 16'd0);
    cmd_r = 8'd60; cmd_g = 8'd0; cmd_b = 8'd128; cmd_div = 16'd5; cmd_valid = 1'b1;
    acc_k = 0;
    for (int k = 1; k <= 100; k++) begin
      if (cmd_ready) begin acc_k = k; break; end
      step_clk();
    end
    chk("hs_accept_cycle", acc_k, 56);
    step_clk();
    cmd_valid = 1'b0;
    chk("hs_noop_done", done, 1);
    chk("hs_noop_busy", busy, 1);
    step_clk();
    chk("hs_ready_back", cmd_ready, 1);
    chk("hs_done_once", done, 0);

    // 5. Abort during 0 -> 200
    send(8'd0, 8'd0, 8'd0, 16'd0);
    wait_idle(200);
    send(8'd200, 8'd0, 8'd0, 16'd0);
    for (int k = 0; k < 100; k++) begin
      if (dut.duty_reg[0] == 8'd50) break;
      step_clk();
    end
    chk("abort_reach50", dut.duty_reg[0], 50);
    abort = 1'b1;
    #1;
    chk("abort_no_done", done, 0);
    step_clk();
    abort = 1'b0;
    chk("abort_idle", {busy, cmd_ready}, 2'b01);
    d = dut.duty_reg[0];
    chk("abort_frozen_val", (d == 8'd50) || (d == 8'd51), 1);
    ndone = 0;
    repeat (5) begin
      ndone += int'(done);
      step_clk();
    end
    chk("abort_hold", dut.duty_reg[0], d);
    chk("abort_no_late_done", ndone, 0);
    // abort together with completion (no-op fade)
    send(d, 8'd0, 8'd0, 16'd0);
    abort = 1'b1;
    #1;
    chk("abort_cmpl_done", done, 0);
    step_clk();
    abort = 1'b0;
    chk("abort_cmpl_idle", {cmd_ready, done}, 2'b10);

    // 6. Asynchronous reset mid-fade
    send(8'd255, 8'd0, 8'd0, 16'd2);
    acc_k = 0;
    for (int k = 0; k < 300; k++) begin
      if (pwm_r) begin acc_k = 1; break; end
      step_clk();
    end
    chk("arst_pwm_seen", acc_k, 1);
    chk("arst_pre_led", led_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pwm_low", pwm_r, 0);
    chk("arst_outs", {led_en, busy, done, cmd_ready}, 0);
    repeat (5) step_clk();
    rst_n = 1'b1;
    #1;
    chk("arst_rel_ready", cmd_ready, 1);
    chk("arst_rel_duty", dut.duty_reg[0], 0);
    chk("arst_rel_cnt", dut.pwm_cnt_reg, 0);
    step_clk();
    send(8'd3, 8'd0, 8'd0, 16'd0);
    first_done = 0;
    for (int k = 1; k <= 10; k++) begin
      if (done && first_done == 0) first_done = k;
      step_clk();
    end
    chk("arst_fade_done", first_done, 4);
    repeat (300) step_clk();
    count_pwm(nr, ng, nb);
    chk("arst_pwm_r_3", nr, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rgb_fade_ctrl.md
Name: rgb_fade_ctrl

Overview:
- Controller that sequences the three PWM inputs of the iCE40 SB_RGBA_DRV hard LED driver (RGB0PWM/RGB1PWM/RGB2PWM, plus RGBLEDEN).
- Holds an 8-bit duty per colour and generates glitch-free PWM from it.
- Accepts fade commands over a valid/ready handshake and ramps each colour linearly toward its target at a programmable rate.
- Sits between the SB_HFOSC-clocked user logic and the LED driver instance.

Parameters:
- PWM_BITS, 8, width of the duty registers and the PWM counter (period = 2^PWM_BITS clocks).
- DIV_BITS, 16, width of the fade-rate divider.

Ports:
- clk  input  1  system clock (SB_HFOSC output).
- rst_n  input  1  asynchronous, active-low reset.
- led_en_in  input  1  LED enable request.
- cmd_valid  input  1  fade command valid.
- cmd_ready  output  1  controller can accept a command.
- cmd_r, cmd_g, cmd_b  input  PWM_BITS each  target duties.
- cmd_div  input  DIV_BITS  clocks per fade step minus 1.
- abort  input  1  stop the fade in progress.
- pwm_r, pwm_g, pwm_b  output  1 each  to the driver PWM inputs.
- led_en  output  1  to the driver RGBLEDEN.
- busy  output  1  fade in progress.
- done  output  1  one-cycle pulse when a fade completes.

Behaviour:
- Reset (rst_n=0, async): pwm_cnt=0, duty_x=0, duty_act_x=0, tgt_x=0, div=0, presc=0, state=IDLE. All outputs 0 except cmd_ready, which is 1 once rst_n=1.
- PWM counter: pwm_cnt increments every clk and wraps 2^PWM_BITS-1 -> 0.
- PWM outputs: pwm_x is registered, pwm_x <= (duty_act_x > pwm_cnt).
  - duty 0 gives always off; duty 255 gives 255/256 on.
  - 1-cycle latency from the counter to the pin.
- Glitch-free update: duty_act_x <= duty_x only in the cycle where pwm_cnt == max. A new duty therefore takes effect from the next period start; no partial periods.
- led_en <= led_en_in, registered. It is independent of the state machine.
- State machine IDLE/FADE:
  - cmd_ready = (state==IDLE).
  - IDLE: when cmd_valid && cmd_ready, latch tgt_x=cmd_x and div=cmd_div, clear presc, go to FADE. Commands are ignored while in FADE (ready=0). cmd_valid must be held until accepted.
  - FADE, prescaler: busy=1. presc increments each cycle; when presc==div it is a tick and presc returns to 0 (div=0 gives a tick every cycle).
  - FADE, tick: each duty_x steps ±1 toward tgt_x; channels already at their target are unchanged. No overshoot; arithmetic never wraps.
  - FADE, completion: checked every cycle. If all duty_x==tgt_x (including on entry), done=1 for exactly that cycle and the next state is IDLE.
  - FADE, abort: abort=1 goes to IDLE next cycle with duty_x frozen, and no done pulse. abort has priority over completion in the same cycle. abort in IDLE has no effect.
- Fade duration: |Δ|max × (div+1) cycles of FADE, plus 1 cycle for the done detection.
- Reset mid-fade: everything returns to the reset values immediately; the PWM outputs drop to 0 asynchronously.

Test Plan:
1. Reset: rst_n low for 5 cycles, then release. pwm_*=0, led_en=0, busy=0, done=0, cmd_ready=1; pwm_cnt=0 on the first post-reset edge.
2. Full fade: command r=255, g=0, b=128, div=0 accepted at cycle T.
   - busy=1 from T+1.
   - done pulses once at T+256; cmd_ready=1 at T+257.
   - Afterwards pwm_r is high 255 of every 256 cycles, pwm_g is never high, pwm_b is high 128 of every 256.
3. Rate and down-ramp: from r=10, command r=6, div=3.
   - duty_r follows 9, 8, 7, 6, one step every 4 cycles.
   - done occurs 17 cycles after accept.
   - duty_act_r changes only when pwm_cnt==255.
4. Handshake: in FADE, hold cmd_valid with new targets. Not accepted while busy; accepted in the cycle cmd_ready returns to 1. A no-op command (targets equal to current) gives done exactly 1 cycle after accept.
5. Abort: during a 0 -> 200 fade (div=0), assert abort when duty_r=50.
   - IDLE next cycle, duty_r frozen at 50 or 51, no done.
   - Assert abort and completion in the same cycle: no done.
6. Async reset mid-fade: drop rst_n between clock edges. Outputs go to 0 without waiting for an edge; after release the block behaves as in scenario 1.
